// File: rtl/sound_frame_seq_if.sv
// Strobe bus between the APU frame sequencer and the channel units.
// The sequencer takes the master side; the channel blocks listen on the slave side.
interface sound_frame_seq_if;
  logic       apu_en;
  logic       div_bit;
  logic       frame_tick;
  logic       clk_length;
  logic       clk_sweep;
  logic       clk_vol_env;
  logic [2:0] step;

  modport master (
    input  apu_en,
    input  div_bit,
    output frame_tick,
    output clk_length,
    output clk_sweep,
    output clk_vol_env,
    output step
  );

  modport slave (
    output apu_en,
    output div_bit,
    input  frame_tick,
    input  clk_length,
    input  clk_sweep,
    input  clk_vol_env,
    input  step
  );
endinterface

// File: rtl/sound_frame_seq.sv
// APU frame sequencer: 512 Hz tick stepping an 8-position table of length/sweep/envelope strobes.
// Define FRAME_SEQ_EXT_DIV_EN to tick on falling edges of the timer DIV bit instead of the prescaler.
module sound_frame_seq #(
  parameter int CLK_DIV = 8192
) (
  input logic               clk,
  input logic               rst,
  sound_frame_seq_if.master bus
);

  typedef enum logic [2:0] {
    STEP0, STEP1, STEP2, STEP3, STEP4, STEP5, STEP6, STEP7
  } step_t;

  step_t step_q;
  logic  tick;
  logic  frame_tick_q;
  logic  clk_length_q;
  logic  clk_sweep_q;
  logic  clk_vol_env_q;

`ifdef FRAME_SEQ_EXT_DIV_EN
  localparam int UNUSED_CLK_DIV = CLK_DIV;

  logic div_prev;

  // The DIV bit is tracked even while the APU is off so re-enabling never sees a stale edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_prev <= 1'b0;
    end else begin
      div_prev <= bus.div_bit;
    end
  end

  assign tick = bus.apu_en & div_prev & ~bus.div_bit;
`else
  localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 1);

  logic [15:0] prescaler;
  logic        unused_div_bit;

  assign unused_div_bit = bus.div_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (!bus.apu_en || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  assign tick = bus.apu_en && (prescaler == LAST_COUNT);
`endif

  // Strobes default low every cycle, so each one is high for exactly the cycle after its tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q        <= STEP0;
      frame_tick_q  <= 1'b0;
      clk_length_q  <= 1'b0;
      clk_sweep_q   <= 1'b0;
      clk_vol_env_q <= 1'b0;
    end else begin
      frame_tick_q  <= 1'b0;
      clk_length_q  <= 1'b0;
      clk_sweep_q   <= 1'b0;
      clk_vol_env_q <= 1'b0;
      if (!bus.apu_en) begin
        step_q <= STEP0;
      end else if (tick) begin
        step_q        <= step_t'(step_q + 3'd1);
        frame_tick_q  <= 1'b1;
        clk_length_q  <= ~step_q[0];
        clk_sweep_q   <= (step_q == STEP2) || (step_q == STEP6);
        clk_vol_env_q <= (step_q == STEP7);
      end
    end
  end

  assign bus.frame_tick  = frame_tick_q;
  assign bus.clk_length  = clk_length_q;
  assign bus.clk_sweep   = clk_sweep_q;
  assign bus.clk_vol_env = clk_vol_env_q;
  assign bus.step        = step_q;

endmodule

// File: tb/tb_sound_frame_seq.sv
// Self-checking bench for sound_frame_seq: step-table vectors, corner sequences and a randomized
// apu_en run compared every cycle against a tick-counting reference model.
module tb_sound_frame_seq;

  localparam int CLK_DIV = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sound_frame_seq_if bus ();

  sound_frame_seq #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       apu_en;
    int         cycles;
    logic       ft;
    logic       len;
    logic       sw;
    logic       env;
    logic [2:0] step;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model: counts enabled cycles and ticks; events come from per-step bit masks.
  logic [7:0] len_mask = 8'b0101_0101;
  logic [7:0] sw_mask  = 8'b0100_0100;
  logic [7:0] env_mask = 8'b1000_0000;
  int   m_cnt;
  int   m_ticks;
  logic m_prev;
  logic m_ft, m_len, m_sw, m_env;

  always @(posedge clk or posedge rst) begin
    bit m_tick;
    int s;
    if (rst) begin
      m_cnt = 0; m_ticks = 0; m_prev = 1'b0;
      m_ft = 1'b0; m_len = 1'b0; m_sw = 1'b0; m_env = 1'b0;
    end else begin
      m_ft = 1'b0; m_len = 1'b0; m_sw = 1'b0; m_env = 1'b0;
`ifdef FRAME_SEQ_EXT_DIV_EN
      m_tick = bus.apu_en && m_prev && !bus.div_bit;
      m_prev = bus.div_bit;
`else
      m_tick = 1'b0;
      if (bus.apu_en) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == CLK_DIV) begin
          m_tick = 1'b1;
          m_cnt  = 0;
        end
      end
`endif
      if (!bus.apu_en) begin
        m_cnt = 0;
        m_ticks = 0;
      end else if (m_tick) begin
        s = m_ticks % 8;
        m_ft  = 1'b1;
        m_len = len_mask[s];
        m_sw  = sw_mask[s];
        m_env = env_mask[s];
        m_ticks = m_ticks + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      checkOutput("model frame_tick", 8'(bus.frame_tick), 8'(m_ft));
      checkOutput("model clk_length", 8'(bus.clk_length), 8'(m_len));
      checkOutput("model clk_sweep", 8'(bus.clk_sweep), 8'(m_sw));
      checkOutput("model clk_vol_env", 8'(bus.clk_vol_env), 8'(m_env));
      checkOutput("model step", 8'(bus.step), 8'(m_ticks % 8));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   n_ft, n_len, n_sw, n_env, n_wide, n_coinc;
    logic p_ft, p_len, p_sw, p_env;

    vecs[0] = '{1'b1, CLK_DIV, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
    vecs[1] = '{1'b1, CLK_DIV, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[2] = '{1'b1, CLK_DIV, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3};
    vecs[3] = '{1'b1, CLK_DIV, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4};
    vecs[4] = '{1'b1, CLK_DIV, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5};
    vecs[5] = '{1'b1, CLK_DIV, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6};
    vecs[6] = '{1'b1, CLK_DIV, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7};
    vecs[7] = '{1'b1, CLK_DIV, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};

    bus.apu_en  = 1'b0;
    bus.div_bit = 1'b0;
    rst = 1'b1;
    #12;
    checkOutput("reset frame_tick", 8'(bus.frame_tick), 8'd0);
    checkOutput("reset clk_length", 8'(bus.clk_length), 8'd0);
    checkOutput("reset clk_sweep", 8'(bus.clk_sweep), 8'd0);
    checkOutput("reset clk_vol_env", 8'(bus.clk_vol_env), 8'd0);
    checkOutput("reset step", 8'(bus.step), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

`ifndef FRAME_SEQ_EXT_DIV_EN
    $display("[TB] step table vectors");
    @(negedge clk);
    for (int v = 0; v < 8; v++) begin
      bus.apu_en = vecs[v].apu_en;
      applyStimulus(vecs[v].cycles);
      checkOutput($sformatf("vec%0d frame_tick", v), 8'(bus.frame_tick), 8'(vecs[v].ft));
      checkOutput($sformatf("vec%0d clk_length", v), 8'(bus.clk_length), 8'(vecs[v].len));
      checkOutput($sformatf("vec%0d clk_sweep", v), 8'(bus.clk_sweep), 8'(vecs[v].sw));
      checkOutput($sformatf("vec%0d clk_vol_env", v), 8'(bus.clk_vol_env), 8'(vecs[v].env));
      checkOutput($sformatf("vec%0d step", v), 8'(bus.step), 8'(vecs[v].step));
    end

    $display("[TB] async reset mid-frame");
    applyStimulus(5 * CLK_DIV);
    checkOutput("pre-reset step", 8'(bus.step), 8'd5);
    applyStimulus(3);
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset step", 8'(bus.step), 8'd0);
    checkOutput("async reset frame_tick", 8'(bus.frame_tick), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(CLK_DIV - 1);
    checkOutput("post-reset early tick", 8'(bus.frame_tick), 8'd0);
    applyStimulus(1);
    checkOutput("post-reset frame_tick", 8'(bus.frame_tick), 8'd1);
    checkOutput("post-reset clk_length", 8'(bus.clk_length), 8'd1);
    checkOutput("post-reset step", 8'(bus.step), 8'd1);

    $display("[TB] apu_en drop mid-frame");
    applyStimulus(2 * CLK_DIV);
    checkOutput("pre-drop step", 8'(bus.step), 8'd3);
    applyStimulus(3);
    bus.apu_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("disabled frame_tick", 8'(bus.frame_tick), 8'd0);
      checkOutput("disabled step", 8'(bus.step), 8'd0);
    end
    bus.apu_en = 1'b1;
    applyStimulus(CLK_DIV - 1);
    checkOutput("re-enable early tick", 8'(bus.frame_tick), 8'd0);
    applyStimulus(1);
    checkOutput("re-enable frame_tick", 8'(bus.frame_tick), 8'd1);
    checkOutput("re-enable clk_length", 8'(bus.clk_length), 8'd1);
    checkOutput("re-enable clk_sweep", 8'(bus.clk_sweep), 8'd0);
    checkOutput("re-enable step", 8'(bus.step), 8'd1);

    $display("[TB] strobe width and rate window");
    n_ft = 0; n_len = 0; n_sw = 0; n_env = 0; n_wide = 0; n_coinc = 0;
    p_ft = 1'b0; p_len = 1'b0; p_sw = 1'b0; p_env = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1);
      n_ft  += int'(bus.frame_tick);
      n_len += int'(bus.clk_length);
      n_sw  += int'(bus.clk_sweep);
      n_env += int'(bus.clk_vol_env);
      if ((p_ft && bus.frame_tick) || (p_len && bus.clk_length) ||
          (p_sw && bus.clk_sweep) || (p_env && bus.clk_vol_env))
        n_wide++;
      if ((bus.clk_vol_env && (bus.clk_length || bus.clk_sweep)) ||
          (bus.clk_sweep && !bus.clk_length))
        n_coinc++;
      p_ft = bus.frame_tick; p_len = bus.clk_length;
      p_sw = bus.clk_sweep;  p_env = bus.clk_vol_env;
    end
    checkOutput("count frame_tick", 8'(n_ft), 8'd128);
    checkOutput("count clk_length", 8'(n_len), 8'd64);
    checkOutput("count clk_sweep", 8'(n_sw), 8'd32);
    checkOutput("count clk_vol_env", 8'(n_env), 8'd16);
    checkOutput("wide strobes", 8'(n_wide), 8'd0);
    checkOutput("strobe coincidence", 8'(n_coinc), 8'd0);
`else
    $display("[TB] DIV bit falling-edge ticks");
    bus.apu_en = 1'b1;
    n_ft = 0;
    for (int i = 0; i < 96; i++) begin
      applyStimulus(1);
      if (i < 64) n_ft += int'(bus.frame_tick);
      if (i == 64) begin
        checkOutput("ext enabled ticks", 8'(n_ft), 8'd8);
        n_ft = 0;
        bus.apu_en = 1'b0;
      end
      if (i > 64) n_ft += int'(bus.frame_tick);
      bus.div_bit = ((i / 4) % 2 == 0);
    end
    checkOutput("ext disabled ticks", 8'(n_ft), 8'd0);

    $display("[TB] DIV write mid-period");
    bus.apu_en  = 1'b1;
    bus.div_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("ext rising no tick", 8'(bus.frame_tick), 8'd0);
    end
    bus.div_bit = 1'b0;
    applyStimulus(1);
    checkOutput("ext div write tick", 8'(bus.frame_tick), 8'd1);
    checkOutput("ext div write length", 8'(bus.clk_length), 8'd1);
    checkOutput("ext div write step", 8'(bus.step), 8'd1);
    p_ft = 1'b0; p_len = 1'b0; p_sw = 1'b0; p_env = 1'b0;
    n_env = 0; n_len = 0; n_sw = 0; n_wide = 0; n_coinc = 0;
`endif

    $display("[TB] randomized apu_en run");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1);
      if (bus.apu_en ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0))
        bus.apu_en = ~bus.apu_en;
`ifdef FRAME_SEQ_EXT_DIV_EN
      if ($urandom_range(0, 3) == 0) bus.div_bit = ~bus.div_bit;
`endif
    end

    applyStimulus(2);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

`ifndef FRAME_SEQ_EXT_DIV_EN
  // div_bit must be ignored without the external-DIV option, so keep it noisy throughout.
  always @(negedge clk) begin
    bus.div_bit = 1'($urandom_range(0, 1));
  end
`endif

endmodule

// File: doc/sound_frame_seq.md
Name: sound_frame_seq

Overview:
APU frame sequencer: the producer of the timing strobes consumed by the channel units (length counters, ch1 frequency sweep, volume envelopes of ch1/2/4).
- Derives a 512 Hz frame tick from the system clock, or optionally from the timer DIV bit.
- Steps an 8-position sequence and emits one-cycle strobes clk_length (256 Hz), clk_sweep (128 Hz) and clk_vol_env (64 Hz).
- Sits in the sound top level between the clock/timer and the channel blocks.

Parameters:
CLK_DIV, 8192, system clocks per frame tick. 4.194304 MHz / 512 = 8192. Legal range 2..65536; the prescaler is 16 bits wide.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
apu_en  input  1  APU master enable (NR52 bit 7); low holds the sequencer cleared
div_bit  input  1  timer DIV bit 4 (512 Hz square); used only with FRAME_SEQ_EXT_DIV_EN, otherwise ignored
frame_tick  output  1  one-cycle pulse per 512 Hz tick
clk_length  output  1  one-cycle length-counter strobe
clk_sweep  output  1  one-cycle frequency-sweep strobe
clk_vol_env  output  1  one-cycle envelope strobe
step  output  3  current sequence position (the step the next tick executes)

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, step=0, div_prev=0.
  - All strobes, including frame_tick, are 0.
- Internal tick condition: apu_en=1 and prescaler==CLK_DIV-1.
- Prescaler:
  - apu_en=1: increments each cycle, wraps to 0 on a tick.
  - apu_en=0: forced to 0 synchronously.
- Step table (events executed when a tick occurs at step s):
  - 0: length
  - 1: none
  - 2: length + sweep
  - 3: none
  - 4: length
  - 5: none
  - 6: length + sweep
  - 7: vol_env
- On the tick edge:
  - step <= step+1, wrapping 7->0.
  - frame_tick <= 1.
  - Each event strobe of the pre-increment step <= 1.
- All strobes are registered and high for exactly one cycle, then return to 0.
- Latency: with apu_en rising while the prescaler is 0, the first frame_tick/clk_length pulse is high in the cycle after CLK_DIV rising edges.
- apu_en=0 (synchronous clear):
  - prescaler=0, step=0, no strobes.
  - A strobe already registered still completes its single cycle.
- apu_en toggled mid-frame: the sequence restarts at step 0 with a full CLK_DIV period. There is no partial-frame carry-over.
- Strobe multiplicity: clk_sweep never fires without clk_length in the same cycle. clk_vol_env never coincides with the other two.
- Strobe rates: exactly one clk_vol_env per 8 ticks, two clk_sweep per 8 ticks, four clk_length per 8 ticks.

Optional Feature:
FRAME_SEQ_EXT_DIV_EN
- Defined:
  - Prescaler is removed; CLK_DIV is unused.
  - div_prev <= div_bit every cycle, regardless of apu_en.
  - Tick condition: apu_en & div_prev & ~div_bit (falling edge of DIV bit 4).
  - Step, strobe and apu_en-clear rules are unchanged.
  - A DIV reset that drops div_bit from 1 to 0 produces an extra tick. This matches hardware.
- Undefined: div_bit is ignored and the internal prescaler drives ticks.

Test Plan:
1. CLK_DIV=8. rst pulse, then apu_en=1 held for 64 cycles -> 8 ticks. Strobe steps are length@0, length+sweep@2, length@4, length+sweep@6, vol_env@7. step reads 0 again after the 8th tick.
2. Async reset mid-frame: rst asserted between clock edges at step 5 -> outputs and step go to 0 immediately, without a clock edge. After release, the first tick fires CLK_DIV cycles later with clk_length.
3. CLK_DIV=8. apu_en dropped at step 3 for 5 cycles, then raised -> no strobes while low, step=0. The next tick fires 8 cycles after re-enable and executes step 0.
4. Pulse width/coincidence over 1024 cycles at CLK_DIV=8 -> every strobe is exactly 1 cycle wide. Counts: 128 frame_tick, 64 clk_length, 32 clk_sweep, 16 clk_vol_env. clk_vol_env never coincides with the other strobes.
5. FRAME_SEQ_EXT_DIV_EN defined, div_bit toggling every 4 cycles -> a tick only on each 1->0 transition, i.e. every 8 cycles. With apu_en=0, a falling edge produces nothing.
6. FRAME_SEQ_EXT_DIV_EN defined: div_bit forced 1->0 mid-period (DIV write) -> one extra tick and step advances by one. A 0->1 transition produces no tick.
